mmio_id_tracker: RTL
====================

Name: mmio_id_tracker

Overview:
- AXI-lite MMIO ID shim between the OFS platform MMIO interface (mmio64_to_afu, which carries IDs) and the Fletcher AxiTop s_axi slave port (which has no ID fields).
- Records each AR and AW ID in order in a per-channel FIFO, and returns that ID with the matching R or B response.
- Replaces the single-register ID capture, which breaks with more than one outstanding read.

Parameters:
- ID_WIDTH, 9, MMIO transaction ID width.
- ADDR_WIDTH, 18, MMIO byte address width.
- DATA_WIDTH, 64, MMIO data width. WSTRB width is DATA_WIDTH/8.
- DEPTH, 4, maximum outstanding transactions per channel. Must be a power of two, 2..64.

Ports:
- clk  in  1  single clock, the host_mem/MMIO clock.
- reset_n  in  1  asynchronous active-low reset.
- s_arvalid/s_arready  in/out  1/1  platform-side AR handshake.
- s_ar_id/s_ar_addr  in  ID_WIDTH/ADDR_WIDTH  read ID and address.
- s_rvalid/s_rready  out/in  1/1  platform-side R handshake.
- s_r_id/s_r_data/s_r_resp/s_r_user  out  ID_WIDTH/DATA_WIDTH/2/1  read response.
- s_awvalid/s_awready/s_aw_id/s_aw_addr  in/out/in/in  1/1/ID_WIDTH/ADDR_WIDTH  write address channel.
- s_wvalid/s_wready/s_w_data/s_w_strb  in/out/in/in  1/1/DATA_WIDTH/DATA_WIDTH/8  write data channel.
- s_bvalid/s_bready/s_b_id/s_b_resp  out/in/out/out  1/1/ID_WIDTH/2  write response channel.
- m_ar*, m_r*, m_aw*, m_w*, m_b*  mirrored  same widths, no id/user  AxiTop-side AXI-lite channels.

Behaviour:
- No internal pipeline registers on the data path.
  - AR, AW, W, R and B all pass through with zero latency.
  - Only the ID FIFOs and their counters are sequential.
- AR path:
  - m_arvalid = s_arvalid & ~rd_full.
  - s_arready = m_arready & ~rd_full.
  - m_ar_addr = s_ar_addr.
  - Push s_ar_id into the read FIFO on s_arvalid & s_arready.
- R path:
  - s_rvalid = m_rvalid & ~rd_empty.
  - m_rready = s_rready & ~rd_empty.
  - s_r_id = read FIFO head. Data and resp pass through. s_r_user is tied to all-ones.
  - Pop on s_rvalid & s_rready.
- AW/B paths: identical to AR/R, using the write FIFO.
- W: pure pass-through. It never blocks on FIFO state.
- FIFO implementation:
  - Register array, with wr_ptr and rd_ptr of width log2(DEPTH) that wrap modulo DEPTH.
  - Occupancy counter of width log2(DEPTH)+1.
  - full = (count == DEPTH); empty = (count == 0).
- Simultaneous push and pop:
  - Allowed when neither full nor empty: count is unchanged and both pointers advance.
  - When full, the push is blocked even if a pop occurs that cycle (conservative; no bypass).
  - When empty, a push lands but the head is not visible until the next cycle (no fall-through).
- Response with empty FIFO (protocol violation upstream): the response is stalled. m_rready and m_bready stay low.
- Reset:
  - Clears pointers and counters. FIFO contents are don't-care.
  - All ready/valid outputs are 0 during reset.
  - Reset mid-operation drops all outstanding IDs. Responses in flight are not returned.
- Ordering: AXI-lite responses are in order per channel, so FIFO order equals response order.

Optional Feature:
- Macro: MMIO_ID_TRACKER_ERR_EN.
- When defined:
  - Adds output err_sticky[1:0]: bit0 = read, bit1 = write.
  - A bit is set on any cycle where m_rvalid (or m_bvalid) is high while the corresponding FIFO is empty.
  - The bit is cleared only by reset_n.
  - Adds outputs rd_outstanding and wr_outstanding, each log2(DEPTH)+1 bits, equal to the FIFO counts.
- When undefined: these ports and their logic are absent. Stall behaviour is unchanged.

Decomposition:
- Package mmio_id_tracker_pkg:
  - function clog2-based width constants (CNT_W, PTR_W);
  - typedef of the ID type;
  - localparam RESP_OKAY = 2'b00.
- Sub-module id_fifo (parameters WIDTH, DEPTH; ports push/pop/din/dout/full/empty/count), instantiated twice.

Test Plan:
- Single read: AR id=0x1A5 addr=0x0040, AxiTop responds after 3 cycles with data 0xDEADBEEF_00000001 -> s_r_id=0x1A5, s_r_user=1, resp=0.
- Four back-to-back ARs with ids 1,2,3,4 and m_rvalid held low -> all accepted; a 5th AR sees s_arready=0 and m_arvalid=0. Release responses -> ids returned 1,2,3,4 in order, then the 5th is accepted.
- Simultaneous push/pop at count=2: AR id=7 accepted in the same cycle an R pops -> count stays 2, next returned id correct.
- Write: AW id=0x055 plus W data=0x1234 strb=0xFF, m_bvalid after 2 cycles -> s_b_id=0x055. W passes through even with the write FIFO full.
- Reset asserted with 3 reads outstanding -> count=0, s_rvalid=0 while m_rvalid=1. With MMIO_ID_TRACKER_ERR_EN, err_sticky[0]=1 from the next cycle onward.
- Pointer wrap: 10 sequential single reads with ids 0..9 -> ids returned correctly across the DEPTH=4 wrap.

Source files
------------

// File: rtl/mmio_id_tracker_pkg.sv
// Shared types and width helpers for the MMIO ID tracker.
// Optional error/occupancy reporting is enabled with MMIO_ID_TRACKER_ERR_EN.
package mmio_id_tracker_pkg;

  localparam int unsigned DEFAULT_ID_WIDTH = 9;
  localparam int unsigned DEFAULT_DEPTH    = 4;

  // Pointer width for a power-of-two FIFO depth.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Occupancy counter width; one extra bit so that "full" is representable.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned PTR_W = ptr_width(DEFAULT_DEPTH);
  localparam int unsigned CNT_W = cnt_width(DEFAULT_DEPTH);

  typedef logic [DEFAULT_ID_WIDTH-1:0] id_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/mmio_id_tracker_id_fifo.sv
// In-order ID FIFO: register array with wrapping pointers and an occupancy count.
// No fall-through and no bypass: push is refused when full, pop when empty.
module id_fifo
  import mmio_id_tracker_pkg::*;
#(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            din,
  output logic [WIDTH-1:0]            dout,
  output logic                        full,
  output logic                        empty,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Status flags and qualified push/pop strobes.
  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    dout    = mem[rd_ptr];
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; contents are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_id_tracker.sv
// AXI-lite ID shim: records AR/AW IDs in per-channel FIFOs and re-attaches
// them to the in-order R/B responses. Data paths are combinational.
// Define MMIO_ID_TRACKER_ERR_EN to add err_sticky and occupancy outputs.
module mmio_id_tracker
  import mmio_id_tracker_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 9,
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  input  logic [ID_WIDTH-1:0]     s_ar_id,
  input  logic [ADDR_WIDTH-1:0]   s_ar_addr,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [ID_WIDTH-1:0]     s_r_id,
  output logic [DATA_WIDTH-1:0]   s_r_data,
  output logic [1:0]              s_r_resp,
  output logic                    s_r_user,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [ID_WIDTH-1:0]     s_aw_id,
  input  logic [ADDR_WIDTH-1:0]   s_aw_addr,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  input  logic [DATA_WIDTH-1:0]   s_w_data,
  input  logic [DATA_WIDTH/8-1:0] s_w_strb,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  output logic [ID_WIDTH-1:0]     s_b_id,
  output logic [1:0]              s_b_resp,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  output logic [ADDR_WIDTH-1:0]   m_ar_addr,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  input  logic [DATA_WIDTH-1:0]   m_r_data,
  input  logic [1:0]              m_r_resp,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [ADDR_WIDTH-1:0]   m_aw_addr,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic [DATA_WIDTH-1:0]   m_w_data,
  output logic [DATA_WIDTH/8-1:0] m_w_strb,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  input  logic [1:0]              m_b_resp
`ifdef MMIO_ID_TRACKER_ERR_EN
  ,
  output logic [1:0]                  err_sticky,
  output logic [cnt_width(DEPTH)-1:0] rd_outstanding,
  output logic [cnt_width(DEPTH)-1:0] wr_outstanding
`endif
);

  localparam int unsigned CW = cnt_width(DEPTH);

  logic                rd_full, rd_empty, wr_full, wr_empty;
  logic                rd_push, rd_pop, wr_push, wr_pop;
  logic [ID_WIDTH-1:0] rd_head, wr_head;
  logic [CW-1:0]       rd_count, wr_count;

  // Handshake gating and zero-latency pass-through; reset_n forces every valid/ready low.
  always_comb begin
    m_arvalid = reset_n & s_arvalid & ~rd_full;
    s_arready = reset_n & m_arready & ~rd_full;
    m_ar_addr = s_ar_addr;
    rd_push   = s_arvalid & s_arready;

    s_rvalid  = reset_n & m_rvalid & ~rd_empty;
    m_rready  = reset_n & s_rready & ~rd_empty;
    s_r_id    = rd_head;
    s_r_data  = m_r_data;
    s_r_resp  = m_r_resp;
    s_r_user  = 1'b1;
    rd_pop    = s_rvalid & s_rready;

    m_awvalid = reset_n & s_awvalid & ~wr_full;
    s_awready = reset_n & m_awready & ~wr_full;
    m_aw_addr = s_aw_addr;
    wr_push   = s_awvalid & s_awready;

    s_bvalid  = reset_n & m_bvalid & ~wr_empty;
    m_bready  = reset_n & s_bready & ~wr_empty;
    s_b_id    = wr_head;
    s_b_resp  = m_b_resp;
    wr_pop    = s_bvalid & s_bready;

    m_wvalid  = reset_n & s_wvalid;
    s_wready  = reset_n & m_wready;
    m_w_data  = s_w_data;
    m_w_strb  = s_w_strb;
  end

  id_fifo #(.WIDTH(ID_WIDTH), .DEPTH(DEPTH)) u_rd_fifo (
    .clk(clk), .reset_n(reset_n), .push(rd_push), .pop(rd_pop), .din(s_ar_id),
    .dout(rd_head), .full(rd_full), .empty(rd_empty), .count(rd_count)
  );

  id_fifo #(.WIDTH(ID_WIDTH), .DEPTH(DEPTH)) u_wr_fifo (
    .clk(clk), .reset_n(reset_n), .push(wr_push), .pop(wr_pop), .din(s_aw_id),
    .dout(wr_head), .full(wr_full), .empty(wr_empty), .count(wr_count)
  );

`ifdef MMIO_ID_TRACKER_ERR_EN
  // Latch any response that arrives with no recorded ID; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_sticky <= '0;
    end else begin
      if (m_rvalid && rd_empty) err_sticky[0] <= 1'b1;
      if (m_bvalid && wr_empty) err_sticky[1] <= 1'b1;
    end
  end

  // Occupancy reporting.
  always_comb begin
    rd_outstanding = rd_count;
    wr_outstanding = wr_count;
  end
`else
  logic unused_counts;

  // Counts are only exported when error reporting is enabled.
  always_comb begin
    unused_counts = ^{rd_count, wr_count};
  end
`endif

endmodule
